// File: rtl/onehot_dec_pkg.sv
// -----------------------------------------------------------------------------
// onehot_dec_pkg
// Shared types and constants for the one-hot scan decoder.
//   state_e      : controller states (IDLE, DIRECT, SCAN, BLANK)
//   MODE_DIRECT  : mode input value selecting direct address decode
//   MODE_SCAN    : mode input value selecting automatic scanning
// -----------------------------------------------------------------------------
package onehot_dec_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2,
    BLANK  = 2'd3
  } state_e;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/dec_nx.sv
// -----------------------------------------------------------------------------
// dec_nx
// Purely combinational N-to-2**N one-hot decoder with enable.
// Ports:
//   en     : in  1      - when low the output is all-zero
//   addr   : in  ADDR_W - bit position to set
//   onehot : out OUT_W  - one-hot result (at most one bit set)
// -----------------------------------------------------------------------------
module dec_nx #(
  parameter  int ADDR_W = 4,
  localparam int OUT_W  = 2 ** ADDR_W
) (
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  output logic [OUT_W-1:0]  onehot
);

  // Decode: clear every bit first, then set the addressed bit if enabled.
  always_comb begin
    onehot = {OUT_W{1'b0}};
    if (en) begin
      onehot[addr] = 1'b1;
    end else begin
      onehot = {OUT_W{1'b0}};
    end
  end

endmodule

// File: rtl/onehot_scan_decoder.sv
// -----------------------------------------------------------------------------
// onehot_scan_decoder
// Registered one-hot select generator. In direct mode it decodes an address
// accepted through a valid/ready handshake; in scan mode it walks a single
// active bit across all outputs, holding each for DWELL cycles followed by
// one blank cycle so that adjacent selects never overlap.
//
// Configuration macro: ONEHOT_SCAN_DECODER_SCAN_EN
//   defined   : SCAN/BLANK states, dwell counter and wrap pulse are built.
//   undefined : mode is ignored, wrap is tied low, direct decode only.
//
// Ports:
//   clk        : in  1      - rising-edge clock
//   rst_n      : in  1      - asynchronous active-low reset
//   en         : in  1      - block enable, low drives outputs inactive
//   mode       : in  1      - 0 direct decode, 1 auto-scan
//   in_valid   : in  1      - address offered (direct mode)
//   in_addr    : in  ADDR_W - address to decode
//   in_ready   : out 1      - high only in DIRECT state
//   out_onehot : out OUT_W  - registered one-hot select
//   out_idx    : out ADDR_W - registered index of the active bit (0 if none)
//   wrap       : out 1      - pulse in the BLANK cycle after the last index
// -----------------------------------------------------------------------------
module onehot_scan_decoder
  import onehot_dec_pkg::*;
#(
  parameter  int ADDR_W = 4,
  parameter  int DWELL  = 4,
  localparam int OUT_W  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              mode,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              in_ready,
  output logic [OUT_W-1:0]  out_onehot,
  output logic [ADDR_W-1:0] out_idx,
  output logic              wrap
);

  state_e              state_q, state_d;
  logic [OUT_W-1:0]    out_onehot_q, out_onehot_d;
  logic [ADDR_W-1:0]   out_idx_q, out_idx_d;
  logic                wrap_q, wrap_d;

  // Address/enable presented to the shared decoder for the next cycle.
  logic [ADDR_W-1:0]   sel_addr_s;
  logic                sel_en_s;
  logic                scan_mode_s;

`ifdef ONEHOT_SCAN_DECODER_SCAN_EN
  localparam int CNT_W = $clog2(DWELL + 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;

  assign scan_mode_s = (mode == MODE_SCAN);
`else
  logic unused_cfg_s;

  assign scan_mode_s  = 1'b0;
  assign unused_cfg_s = mode ^ (DWELL > 0);
`endif

  // Ready depends only on the state so no path exists from in_valid.
  assign in_ready   = (state_q == DIRECT);
  assign out_onehot = out_onehot_q;
  assign out_idx    = out_idx_q;
  assign wrap       = wrap_q;

  // Next-state, scan position and decoder selection.
  always_comb begin
    state_d    = state_q;
    sel_en_s   = |out_onehot_q;
    sel_addr_s = out_idx_q;
    wrap_d     = 1'b0;
`ifdef ONEHOT_SCAN_DECODER_SCAN_EN
    cnt_d      = cnt_q;
    idx_d      = idx_q;
`endif
    if (!en) begin
      state_d    = IDLE;
      sel_en_s   = 1'b0;
      sel_addr_s = {ADDR_W{1'b0}};
`ifdef ONEHOT_SCAN_DECODER_SCAN_EN
      cnt_d      = {CNT_W{1'b0}};
      idx_d      = {ADDR_W{1'b0}};
`endif
    end else begin
      case (state_q)
        IDLE: begin
          sel_en_s   = 1'b0;
          sel_addr_s = {ADDR_W{1'b0}};
`ifdef ONEHOT_SCAN_DECODER_SCAN_EN
          if (scan_mode_s) begin
            // Scan always starts from bit 0 with the first dwell cycle.
            state_d    = SCAN;
            idx_d      = {ADDR_W{1'b0}};
            cnt_d      = CNT_W'(1);
            sel_en_s   = 1'b1;
            sel_addr_s = {ADDR_W{1'b0}};
          end else begin
            state_d = DIRECT;
          end
`else
          state_d = DIRECT;
`endif
        end
        DIRECT: begin
          if (scan_mode_s) begin
            // Clear outputs for one cycle; IDLE then launches the scan.
            state_d    = IDLE;
            sel_en_s   = 1'b0;
            sel_addr_s = {ADDR_W{1'b0}};
          end else if (in_valid) begin
            sel_en_s   = 1'b1;
            sel_addr_s = in_addr;
          end else begin
            sel_en_s   = |out_onehot_q;
            sel_addr_s = out_idx_q;
          end
        end
`ifdef ONEHOT_SCAN_DECODER_SCAN_EN
        SCAN: begin
          // Leaving scan mode cuts the dwell short but still passes BLANK.
          if (!scan_mode_s || (cnt_q >= CNT_W'(DWELL))) begin
            state_d    = BLANK;
            sel_en_s   = 1'b0;
            sel_addr_s = {ADDR_W{1'b0}};
            cnt_d      = {CNT_W{1'b0}};
            idx_d      = idx_q + ADDR_W'(1);
            wrap_d     = (idx_q == ADDR_W'(OUT_W - 1));
          end else begin
            cnt_d      = cnt_q + CNT_W'(1);
            sel_en_s   = 1'b1;
            sel_addr_s = idx_q;
          end
        end
        BLANK: begin
          if (scan_mode_s) begin
            state_d    = SCAN;
            cnt_d      = CNT_W'(1);
            sel_en_s   = 1'b1;
            sel_addr_s = idx_q;
          end else begin
            state_d    = IDLE;
            idx_d      = {ADDR_W{1'b0}};
            sel_en_s   = 1'b0;
            sel_addr_s = {ADDR_W{1'b0}};
          end
        end
`endif
        default: begin
          state_d    = IDLE;
          sel_en_s   = 1'b0;
          sel_addr_s = {ADDR_W{1'b0}};
        end
      endcase
    end
  end

  // Single shared decoder drives both direct and scan selects.
  dec_nx #(
    .ADDR_W (ADDR_W)
  ) u_dec (
    .en     (sel_en_s),
    .addr   (sel_addr_s),
    .onehot (out_onehot_d)
  );

  // Index output follows the decoder input, forced to 0 when inactive.
  always_comb begin
    out_idx_d = {ADDR_W{1'b0}};
    if (sel_en_s) begin
      out_idx_d = sel_addr_s;
    end else begin
      out_idx_d = {ADDR_W{1'b0}};
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      out_onehot_q <= {OUT_W{1'b0}};
      out_idx_q    <= {ADDR_W{1'b0}};
      wrap_q       <= 1'b0;
`ifdef ONEHOT_SCAN_DECODER_SCAN_EN
      cnt_q        <= {CNT_W{1'b0}};
      idx_q        <= {ADDR_W{1'b0}};
`endif
    end else begin
      state_q      <= state_d;
      out_onehot_q <= out_onehot_d;
      out_idx_q    <= out_idx_d;
      wrap_q       <= wrap_d;
`ifdef ONEHOT_SCAN_DECODER_SCAN_EN
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
`endif
    end
  end

endmodule

// File: tb/tb_onehot_scan_decoder.sv
// -----------------------------------------------------------------------------
// tb_onehot_scan_decoder
// Directed self-checking bench for onehot_scan_decoder (ADDR_W=4, DWELL=3).
// Expected outputs are queued as each step is driven and compared after the
// following rising edge. Scan-specific steps follow the configuration macro.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_onehot_scan_decoder;

  localparam int ADDR_W = 4;
  localparam int DWELL  = 3;
  localparam int OUT_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic              mode;
  logic              in_valid;
  logic [ADDR_W-1:0] in_addr;
  logic              in_ready;
  logic [OUT_W-1:0]  out_onehot;
  logic [ADDR_W-1:0] out_idx;
  logic              wrap;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string             tag;
    logic [OUT_W-1:0]  oh;
    logic [ADDR_W-1:0] idx;
    logic              wr;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  onehot_scan_decoder #(
    .ADDR_W (ADDR_W),
    .DWELL  (DWELL)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .mode       (mode),
    .in_valid   (in_valid),
    .in_addr    (in_addr),
    .in_ready   (in_ready),
    .out_onehot (out_onehot),
    .out_idx    (out_idx),
    .wrap       (wrap)
  );

  task automatic chk_ready(input string tag, input logic exp);
    checks++;
    assert (in_ready === exp) else begin
      errors++;
      $error("FAIL %s in_ready observed=%0b expected=%0b", tag, in_ready, exp);
    end
  endtask

  task automatic push(input string tag, input logic [OUT_W-1:0] oh,
                      input logic [ADDR_W-1:0] idx, input logic wr);
    exp_t e;
    e.tag = tag;
    e.oh  = oh;
    e.idx = idx;
    e.wr  = wr;
    sb.push_back(e);
  endtask

  task automatic compare_head();
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1 entries");
    end else begin
      e = sb.pop_front();
      assert (out_onehot === e.oh) else begin
        errors++;
        $error("FAIL %s out_onehot observed=%h expected=%h", e.tag, out_onehot, e.oh);
      end
      checks++;
      assert (out_idx === e.idx) else begin
        errors++;
        $error("FAIL %s out_idx observed=%0d expected=%0d", e.tag, out_idx, e.idx);
      end
      checks++;
      assert (wrap === e.wr) else begin
        errors++;
        $error("FAIL %s wrap observed=%0b expected=%0b", e.tag, wrap, e.wr);
      end
    end
  endtask

  // One clock step: queue the expectation, clock, then compare away from the edge.
  task automatic step(input string tag, input logic [OUT_W-1:0] oh,
                      input logic [ADDR_W-1:0] idx, input logic wr);
    push(tag, oh, idx, wr);
    @(posedge clk);
    #1;
    compare_head();
  endtask

  // Reference scan pattern: c counts cycles since entering SCAN at index 0.
  task automatic scan_step(input int c);
    int pos;
    int k;
    int ph;
    logic [ADDR_W-1:0] kk;
    pos = c % (OUT_W * (DWELL + 1));
    k   = pos / (DWELL + 1);
    ph  = pos % (DWELL + 1);
    kk  = ADDR_W'(k);
    if (ph < DWELL) begin
      step("scan_active", 16'h0001 << k, kk, 1'b0);
    end else begin
      step("scan_blank", 16'h0000, 4'd0, (k == OUT_W - 1));
    end
  endtask

  initial begin
    int wraps;
    rst_n    = 1'b0;
    en       = 1'b0;
    mode     = 1'b0;
    in_valid = 1'b0;
    in_addr  = 4'h0;
    #2;
    push("reset", 16'h0000, 4'd0, 1'b0);
    compare_head();
    chk_ready("reset_ready", 1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    step("idle_after_reset", 16'h0000, 4'd0, 1'b0);

    // Direct decode with handshake and hold.
    en = 1'b1;
    mode = 1'b0;
    chk_ready("idle_ready", 1'b0);
    step("to_direct", 16'h0000, 4'd0, 1'b0);
    chk_ready("direct_ready", 1'b1);
    in_valid = 1'b1;
    in_addr  = 4'hA;
    step("direct_A", 16'h0400, 4'd10, 1'b0);
    in_valid = 1'b0;
    in_addr  = 4'h3;
    step("direct_hold", 16'h0400, 4'd10, 1'b0);
    in_valid = 1'b1;
    in_addr  = 4'h0;
    step("direct_0", 16'h0001, 4'd0, 1'b0);
    in_addr  = 4'hF;
    step("direct_F", 16'h8000, 4'd15, 1'b0);
    in_valid = 1'b0;
    en = 1'b0;
    step("en_low_direct", 16'h0000, 4'd0, 1'b0);
    chk_ready("en_low_ready", 1'b0);
    step("idle_hold", 16'h0000, 4'd0, 1'b0);

`ifdef ONEHOT_SCAN_DECODER_SCAN_EN
    // Full scan sweep past one wrap, stopping at index 5 mid-dwell.
    en = 1'b1;
    mode = 1'b1;
    wraps = 0;
    for (int c = 0; c <= 85; c++) begin
      chk_ready("scan_ready", 1'b0);
      scan_step(c);
      if (wrap === 1'b1) wraps++;
      if (c == 69) begin
        checks++;
        assert (wraps === 1) else begin
          errors++;
          $error("FAIL wrap_count observed=%0d expected=1", wraps);
        end
      end
    end

    // Drop enable at index 5, then restart from bit 0.
    en = 1'b0;
    step("scan_en_drop", 16'h0000, 4'd0, 1'b0);
    en = 1'b1;
    scan_step(0);
    for (int c = 1; c <= 60; c++) begin
      scan_step(c);
    end

    // Leave scan mode at index 15: BLANK with wrap, IDLE, DIRECT.
    mode = 1'b0;
    step("mode_drop_blank", 16'h0000, 4'd0, 1'b1);
    step("mode_drop_idle", 16'h0000, 4'd0, 1'b0);
    chk_ready("mode_drop_idle_ready", 1'b0);
    step("mode_drop_direct", 16'h0000, 4'd0, 1'b0);
    chk_ready("mode_drop_direct_ready", 1'b1);

    // Switch to scan from DIRECT: outputs cleared, then scan from bit 0.
    in_valid = 1'b1;
    in_addr  = 4'h5;
    step("direct_5", 16'h0020, 4'd5, 1'b0);
    in_valid = 1'b0;
    mode = 1'b1;
    step("direct_to_scan_clear", 16'h0000, 4'd0, 1'b0);
    chk_ready("direct_to_scan_ready", 1'b0);
    step("direct_to_scan_bit0", 16'h0001, 4'd0, 1'b0);
    step("dwell_bit0", 16'h0001, 4'd0, 1'b0);

    // Asynchronous reset mid-dwell clears outputs without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    push("async_reset", 16'h0000, 4'd0, 1'b0);
    compare_head();
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step("post_reset_idle", 16'h0000, 4'd0, 1'b0);
    en = 1'b1;
    mode = 1'b1;
    step("scan_from_zero", 16'h0001, 4'd0, 1'b0);
    step("scan_from_zero_dwell", 16'h0001, 4'd0, 1'b0);
`else
    // Scan disabled: mode ignored, decode only, wrap never asserted.
    en = 1'b1;
    mode = 1'b1;
    step("nm_to_direct", 16'h0000, 4'd0, 1'b0);
    chk_ready("nm_direct_ready", 1'b1);
    in_valid = 1'b1;
    in_addr  = 4'h3;
    step("nm_direct_3", 16'h0008, 4'd3, 1'b0);
    in_valid = 1'b0;
    for (int c = 0; c < 100; c++) begin
      in_addr = 4'($urandom_range(0, 15));
      step("nm_hold_nowrap", 16'h0008, 4'd3, 1'b0);
    end
    chk_ready("nm_ready_end", 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
